// File: rtl/dff_pkg.sv
// dff_pkg: shared types for the flip-flop stage input conditioners
package dff_pkg;
   typedef enum logic {STABLE, CHECK} deb_state_e;
endpackage

// File: rtl/sync_chain.sv
// sync_chain: generic flop synchroniser; clk, rst (async active-low), d (raw level) -> q (synchronised level)
module sync_chain #(
   parameter int STAGES      = 2,
   parameter bit RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] chain_q, chain_d;
   always_comb chain_d = {chain_q[STAGES-2:0], d};
   always_ff @(posedge clk or negedge rst)
      if (!rst) chain_q <= {STAGES{RESET_LEVEL}};
      else      chain_q <= chain_d;
   assign q = chain_q[STAGES-1];
endmodule

// File: rtl/d_input_debouncer.sv
// d_input_debouncer: synchronise and debounce din; clk, rst (async active-low), din, en (sample tick) -> dout (debounced), rise/fall (1-cycle edge pulses), busy (qualifying a change)
module d_input_debouncer import dff_pkg::*; #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 8,
   parameter bit RESET_LEVEL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   input  logic en,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic busy
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   logic s, flip;
   deb_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic dout_q, dout_d, rise_q, rise_d, fall_q, fall_d;
   sync_chain #(.STAGES(SYNC_STAGES), .RESET_LEVEL(RESET_LEVEL)) u_sync (
      .clk(clk), .rst(rst), .d(din), .q(s)
   );
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      flip    = 1'b0;
      if (state_q == STABLE) begin
         if (en && s != dout_q) begin
            if (DEBOUNCE_CYCLES == 1) flip = 1'b1;
            else begin
               state_d = CHECK;
               cnt_d   = CNT_W'(1);
            end
         end
      end else if (s == dout_q) begin
         // a bounce back to the current level aborts even on non-sample cycles
         state_d = STABLE;
         cnt_d   = '0;
      end else if (en) begin
         if (cnt_q == CNT_LAST) begin
            flip    = 1'b1;
            state_d = STABLE;
            cnt_d   = '0;
         end else cnt_d = cnt_q + CNT_W'(1);
      end
      dout_d = flip ? s : dout_q;
      rise_d = flip & s;
      fall_d = flip & ~s;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= STABLE;
         cnt_q   <= '0;
         dout_q  <= RESET_LEVEL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   assign dout = dout_q;
   assign rise = rise_q;
   assign fall = fall_q;
   assign busy = (state_q == CHECK);
endmodule
